// File: rtl/bcd_conv_sched.sv
`default_nettype none
// ============================================================================
// Module      : bcd_conv_sched
// Description : Round-robin scheduler that shares one sequential
//               binary-to-BCD engine between NCH sample channels. It accepts
//               per-channel requests and launches one conversion at a time.
//               Each conversion is supervised by a timeout. The result is
//               returned with its channel tag over a valid/ready interface.
// Ports       : pll_clk_33m  clock, all logic on the rising edge
//               sys_rst      synchronous active-high reset
//               req          per-channel request level (held until grant)
//               req_data     channel i sample at [i*DW +: DW]
//               grant        one-hot 1-cycle pulse, request accepted
//               conv_start   1-cycle start pulse to the engine
//               conv_data    operand to the engine
//               conv_done    engine completion pulse, conv_bcd valid
//               conv_bcd     {hun,ten,unit} from the engine
//               res_valid    result available
//               res_ready    consumer accepts result
//               res_ch       channel index of the result
//               res_bcd      {hun,ten,unit}
//               res_ovf      captured sample exceeded 999
//               err_timeout  1-cycle pulse, engine did not answer in time
//               busy         scheduler not idle
// Revision    : 1.0  initial release
// ============================================================================
module bcd_conv_sched #(
   parameter int  NCH     = 8,
   parameter int  DW      = 10,
   parameter int  TIMEOUT = 64,
   localparam int CW      = $clog2(NCH)
) (
   input  logic              pll_clk_33m,
   input  logic              sys_rst,
   input  logic [NCH-1:0]    req,
   input  logic [NCH*DW-1:0] req_data,
   output logic [NCH-1:0]    grant,
   output logic              conv_start,
   output logic [DW-1:0]     conv_data,
   input  logic              conv_done,
   input  logic [11:0]       conv_bcd,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CW-1:0]     res_ch,
   output logic [11:0]       res_bcd,
   output logic              res_ovf,
   output logic              err_timeout,
   output logic              busy
);

   localparam int TW    = $clog2(TIMEOUT + 1);
   // Overflow compare is done at least 10 bits wide so 999 is representable.
   localparam int OVF_W = (DW > 10) ? DW : 10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_OUT    = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   ptr;
   logic [CW-1:0]   cur_ch;
   logic [CW-1:0]   sel_ch;
   logic [CW-1:0]   next_ch;
   logic [TW-1:0]   timer;
   logic            timeout_hit;
   logic [DW-1:0]   ch_data [NCH];
   int              scan_idx;

   for (genvar i = 0; i < NCH; i++) begin : g_unpack
      assign ch_data[i] = req_data[i*DW +: DW];
   end

   // Round-robin pick: walk from the highest offset down to offset 0 so the
   // last assignment is the first requester at or after ptr.
   always_comb begin
      sel_ch   = '0;
      scan_idx = 0;
      for (int k = NCH - 1; k >= 0; k--) begin
         scan_idx = int'(ptr) + k;
         if (scan_idx >= NCH) begin
            scan_idx = scan_idx - NCH;
         end
         if (req[scan_idx]) begin
            sel_ch = CW'(scan_idx);
         end
      end
   end

   assign next_ch     = (cur_ch == CW'(NCH - 1)) ? '0 : cur_ch + 1'b1;
   assign timeout_hit = (timer == TW'(TIMEOUT - 1));
   assign busy        = (state != S_IDLE);

   always_ff @(posedge pll_clk_33m) begin
      if (sys_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (|req) state_nxt = S_LAUNCH;
         S_LAUNCH: state_nxt = S_WAIT;
         S_WAIT: begin
            // Completion takes priority over a coincident timeout.
            if (conv_done) begin
               state_nxt = S_OUT;
            end else if (timeout_hit) begin
               state_nxt = S_IDLE;
            end
         end
         S_OUT:    if (res_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge pll_clk_33m) begin
      if (sys_rst) begin
         ptr         <= '0;
         cur_ch      <= '0;
         timer       <= '0;
         grant       <= '0;
         conv_start  <= 1'b0;
         conv_data   <= '0;
         res_valid   <= 1'b0;
         res_ch      <= '0;
         res_bcd     <= '0;
         res_ovf     <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         grant       <= '0;
         conv_start  <= 1'b0;
         err_timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  conv_data <= ch_data[sel_ch];
                  cur_ch    <= sel_ch;
                  grant     <= {{(NCH-1){1'b0}}, 1'b1} << sel_ch;
               end
            end
            S_LAUNCH: begin
               conv_start <= 1'b1;
               timer      <= '0;
            end
            S_WAIT: begin
               timer <= timer + 1'b1;
               if (conv_done) begin
                  res_valid <= 1'b1;
                  res_bcd   <= conv_bcd;
                  res_ch    <= cur_ch;
                  res_ovf   <= (OVF_W'(conv_data) > OVF_W'(999));
               end else if (timeout_hit) begin
                  err_timeout <= 1'b1;
                  ptr         <= next_ch;
               end
            end
            S_OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  ptr       <= next_ch;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
